au_arbiter: RTL
===============

# au_arbiter

Two-port round-robin arbiter and sequencer for the shared arithmetic unit (AU). It accepts operation requests from two requesters over valid/ready handshakes and drives the AU's mode, operands and edge-triggered `AU_op_enable` strobe in a fixed sequence. It captures `AU_out`, screens NOP, divide-by-zero and illegal opcodes, and returns the result to the granted requester over a valid/ready response channel. It sits between the co-processor issue logic and the AU.

## Interface
- `DW`, default `DATA_WIDTH`: operand/result width.
- `OW`, default `OPCODE_WIDTH`: mode width; encodings are `NOP`, `ADD`, `SUB`, `MULT` and `DIV` from the instruction-set header.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when valid&ready.
- `req0_mode`, `req1_mode`  in  OW  opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DW  operands.
- `rsp0_valid`, `rsp1_valid`  out  1  result available.
- `rsp0_ready`, `rsp1_ready`  in  1  result consumed when valid&ready.
- `rsp_data`  out  DW  result; shared by both ports and meaningful only with a valid.
- `rsp_err`  out  1  error flag for the current response: divide-by-zero or illegal opcode.
- `AU_op_enable`  out  1  AU strobe; the AU acts on its rising edge.
- `AU_mode`  out  OW  AU opcode.
- `AU_in_1`, `AU_in_2`  out  DW  AU operands.
- `AU_out`  in  DW  AU result.
- `busy`  out  1  high in every state except IDLE.
- `ops_done`  out  16  count of completed AU firings; wraps.

## Operation
- State machine has four states: IDLE, SETUP, FIRE and RESP.
- IDLE:
  - The port selected by round-robin gets `reqN_ready`=1. The other port's ready is 0.
  - Selection rule: if only one port is valid, that port is selected. If both are valid, the port not in `last_grant` is selected. If neither is valid, the port not in `last_grant` shows ready.
  - On valid&ready: latch mode and operands into `AU_mode`/`AU_in_1`/`AU_in_2`, set `last_grant`, record the granted port, and classify the request.
  - ADD/SUB/MULT, and DIV with b≠0: go to SETUP.
  - NOP: go to RESP with data=0, err=0.
  - DIV with b=0: go to RESP with data=all-ones, err=1. The AU is not fired.
  - Any other opcode: go to RESP with data=0, err=1.
- SETUP: mode/operands stable; `AU_op_enable`=0. Go to FIRE.
- FIRE: `AU_op_enable`=1 for exactly this cycle. At the closing edge: capture `AU_out` into `rsp_data`, set err=0, increment `ops_done`, go to RESP.
- RESP:
  - The granted port's `rspN_valid`=1; the other port's is 0.
  - `rsp_data`/`rsp_err` are held stable.
  - On `rspN_ready`=1, go to IDLE.
  - A ready on the non-granted port is ignored.
- `AU_mode`/`AU_in_*` hold their last latched values outside SETUP/FIRE.
- Only one operation is in flight; no requests are accepted outside IDLE.
- The AU result is fixed by the AU at `DW` bits. Overflow, SUB wrap and MULT truncation pass through unmodified.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=1, so port 0 wins the first tie.
  - `AU_op_enable`=0, `AU_mode`=0, `AU_in_*`=0.
  - `rsp*_valid`=0, `rsp_data`=0, `rsp_err`=0, `ops_done`=0, `busy`=0.
- `reqN_ready` is combinational from state, `last_grant` and the valids. All other outputs are registered.
- Fired op: accept at edge 0 → SETUP in cycle 1 → FIRE in cycle 2 → `rspN_valid` high from cycle 3.
- Screened op (NOP/err): accept at edge 0 → `rspN_valid` high from cycle 1.
- Response with ready already high: valid lasts one cycle, then IDLE. Earliest next accept is the cycle after.
- Back-to-back fired ops: throughput is one op per 4 cycles.
- `AU_op_enable` rising edge is always ≥1 cycle after the operands change. Its falling edge coincides with the capture edge.
- Reset asserted mid-operation: all state clears immediately and asynchronously. `AU_op_enable` drops, the pending op and its response are discarded, and no `ops_done` increment occurs.
- `ops_done` wraps 0xFFFF→0x0000.

## Test plan
- Single ADD on port 0 (a=3, b=2) → `AU_op_enable` is high for exactly 1 cycle, 2 cycles after accept. `rsp0_valid` in cycle 3 with `rsp_data`=5, err=0. `ops_done`=1.
- Both ports valid every cycle: port 0 SUB 7−9, port 1 MULT 6×7 → grants alternate 0,1,0,1. Port 0 gets `rsp_data`=2^DW−2; port 1 gets 42.
- DIV 10/0 on port 1 → `rsp1_valid` in cycle 1, `rsp_data`=all-ones, err=1, no `AU_op_enable` pulse, `ops_done` unchanged. A following DIV 10/3 returns 3.
- NOP, then illegal opcode → both respond in cycle 1 with data=0. err is 0 for the NOP and 1 for the illegal opcode. The AU is never fired.
- `rsp0_ready` held low for 5 cycles → `rsp0_valid` and data held stable. `req1_valid` is not accepted (ready low) until after the response handshake.
- `reset` pulsed during FIRE → `AU_op_enable` and `busy` drop in the same cycle. No response is issued. After release a tie is granted to port 0.

Source files
------------

// File: rtl/au_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : au_arbiter
// Description : Two-port round-robin arbiter and sequencer for the shared AU.
//               Screens NOP/div-by-zero/illegal opcodes and returns results.
// Revision    : 1.0 - initial release
// ============================================================================
module au_arbiter #(
  parameter int DW = 16,
  parameter int OW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [OW-1:0] req0_mode,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [OW-1:0] req1_mode,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          AU_op_enable,
  output logic [OW-1:0] AU_mode,
  output logic [DW-1:0] AU_in_1,
  output logic [DW-1:0] AU_in_2,
  input  logic [DW-1:0] AU_out,
  output logic          busy,
  output logic [15:0]   ops_done
);

  localparam logic [OW-1:0] c_OP_NOP  = OW'(0);
  localparam logic [OW-1:0] c_OP_ADD  = OW'(1);
  localparam logic [OW-1:0] c_OP_SUB  = OW'(2);
  localparam logic [OW-1:0] c_OP_MULT = OW'(3);
  localparam logic [OW-1:0] c_OP_DIV  = OW'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FIRE  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_last_grant;
  logic          r_grant;

  logic          w_idle;
  logic          w_sel;
  logic          w_accept;
  logic          w_fires;
  logic          w_b_zero;
  logic [OW-1:0] w_mode;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;

  // Round-robin pick: a lone valid wins, otherwise the port not granted last.
  always_comb begin
    w_idle = (r_state == S_IDLE);
    if (req0_valid && !req1_valid)
      w_sel = 1'b0;
    else if (req1_valid && !req0_valid)
      w_sel = 1'b1;
    else
      w_sel = ~r_last_grant;
    w_mode   = w_sel ? req1_mode : req0_mode;
    w_a      = w_sel ? req1_a    : req0_a;
    w_b      = w_sel ? req1_b    : req0_b;
    w_accept = w_idle && (w_sel ? req1_valid : req0_valid);
    w_b_zero = (w_b == '0);
    w_fires  = (w_mode == c_OP_ADD) || (w_mode == c_OP_SUB) ||
               (w_mode == c_OP_MULT) || ((w_mode == c_OP_DIV) && !w_b_zero);
  end

  assign req0_ready = w_idle && !w_sel;
  assign req1_ready = w_idle && w_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      AU_op_enable <= 1'b0;
      AU_mode      <= '0;
      AU_in_1      <= '0;
      AU_in_2      <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      ops_done     <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            AU_mode      <= w_mode;
            AU_in_1      <= w_a;
            AU_in_2      <= w_b;
            r_last_grant <= w_sel;
            r_grant      <= w_sel;
            busy         <= 1'b1;
            if (w_fires) begin
              r_state <= S_SETUP;
            end else begin
              // Screened ops answer immediately without touching the AU.
              r_state    <= S_RESP;
              rsp_data   <= (w_mode == c_OP_DIV) ? {DW{1'b1}} : {DW{1'b0}};
              rsp_err    <= (w_mode != c_OP_NOP);
              rsp0_valid <= ~w_sel;
              rsp1_valid <= w_sel;
            end
          end
        end
        S_SETUP: begin
          r_state      <= S_FIRE;
          AU_op_enable <= 1'b1;
        end
        S_FIRE: begin
          r_state      <= S_RESP;
          AU_op_enable <= 1'b0;
          rsp_data     <= AU_out;
          rsp_err      <= 1'b0;
          ops_done     <= ops_done + 16'd1;
          rsp0_valid   <= ~r_grant;
          rsp1_valid   <= r_grant;
        end
        S_RESP: begin
          if (r_grant ? rsp1_ready : rsp0_ready) begin
            r_state    <= S_IDLE;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
